dmem_access_unit: RTL

- MEM-stage responder for the memory-control fields latched by the EX/MEM pipeline register.
- Decodes the load/store encodings and aligns store data and byte enables.
- Runs a multi-cycle request/ready handshake with the data memory, and sign- or zero-extends load data.
- Drives BUSYWAIT to stall the pipeline while an access is in flight, and reports misaligned, conflicting and timed-out accesses.

---
 rtl/dmem_access_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access unit: decodes load/store controls, aligns store lanes,
// runs the request/ready handshake with data memory and extends load results.
`timescale 1ns/1ps
module dmem_access_unit #(
  parameter int ADDR_WIDTH     = 30,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           MEM_ALU_OUT,
  input  logic [31:0]           MEM_REG_DATA2,
  input  logic [3:0]            MEM_DATA_MEM_READ,
  input  logic [2:0]            MEM_DATA_MEM_WRITE,
  output logic [31:0]           LOAD_DATA,
  output logic                  BUSYWAIT,
  output logic                  FAULT,
  output logic [1:0]            FAULT_CAUSE,
  output logic [ADDR_WIDTH-1:0] DMEM_ADDR,
  output logic                  DMEM_READ,
  output logic                  DMEM_WRITE,
  output logic [31:0]           DMEM_WRITEDATA,
  output logic [3:0]            DMEM_BYTE_EN,
  input  logic [31:0]           DMEM_READDATA,
  input  logic                  DMEM_READY
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [31:0]             load_data_q, load_data_d;
  logic                    fault_q, fault_d;
  logic [1:0]              cause_q, cause_d;
  logic                    rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [2:0]              f3_q, f3_d;
  logic [1:0]              lane_q, lane_d;

  logic       ld_en, st_en, req, illegal, misaligned;
  logic [2:0] ld_f3;
  logic [1:0] st_f3, size;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sf, input logic [31:0] rs2);
    case (sf)
      2'b00:   return {4{rs2[7:0]}};
      2'b01:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sf, input logic [1:0] lane);
    case (sf)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign ld_en = MEM_DATA_MEM_READ[3];
  assign ld_f3 = MEM_DATA_MEM_READ[2:0];
  assign st_en = MEM_DATA_MEM_WRITE[2];
  assign st_f3 = MEM_DATA_MEM_WRITE[1:0];
  assign req   = ld_en | st_en;
  assign size  = ld_en ? ld_f3[1:0] : st_f3;

  assign illegal = (ld_en & st_en)
                 | (ld_en & ((ld_f3 == 3'b011) | (ld_f3[2:1] == 2'b11)))
                 | (st_en & (st_f3 == 2'b11));
  assign misaligned = ((size == 2'b01) & MEM_ALU_OUT[0])
                    | ((size == 2'b10) & (MEM_ALU_OUT[1:0] != 2'b00));

  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    cause_d     = cause_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal || misaligned) begin
            state_d     = DONE;
            fault_d     = 1'b1;
            cause_d     = illegal ? 2'b11 : 2'b01;
            load_data_d = '0;
          end else begin
            state_d = ACCESS;
            addr_d  = MEM_ALU_OUT[ADDR_WIDTH+1:2];
            rd_d    = ld_en;
            wr_d    = st_en;
            be_d    = ld_en ? 4'b1111 : store_be(st_f3, MEM_ALU_OUT[1:0]);
            wdata_d = ld_en ? 32'd0 : store_data(st_f3, MEM_REG_DATA2);
            cnt_d   = '0;
            f3_d    = ld_f3;
            lane_d  = MEM_ALU_OUT[1:0];
          end
        end
      end
      ACCESS: begin
        // READY takes priority over a timeout expiring in the same cycle
        if (DMEM_READY) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) load_data_d = load_extend(DMEM_READDATA, f3_q, lane_q);
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIMIT)) begin
          state_d     = DONE;
          fault_d     = 1'b1;
          cause_d     = 2'b10;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        fault_d = 1'b0;
        cause_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      load_data_q <= '0;
      fault_q     <= 1'b0;
      cause_q     <= 2'b00;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
    end
  end

  assign BUSYWAIT       = ((state_q == IDLE) & req) | (state_q == ACCESS);
  assign LOAD_DATA      = load_data_q;
  assign FAULT          = fault_q;
  assign FAULT_CAUSE    = cause_q;
  assign DMEM_ADDR      = addr_q;
  assign DMEM_READ      = rd_q;
  assign DMEM_WRITE     = wr_q;
  assign DMEM_WRITEDATA = wdata_q;
  assign DMEM_BYTE_EN   = be_q;

endmodule
